// File: rtl/delay_ctrl_pkg.sv
// Shared types and defaults for the delay-line sequencer.
package delay_ctrl_pkg;

    localparam int unsigned A_WIDTH_DEF = 9;
    localparam int unsigned MIN_OFFSET  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } dl_state_t;

endpackage

// File: rtl/delay_line_ctrl.sv
// Delay-line sequencer: turns sample ticks into wr/rd/ptr_en pulses, manages offset
// changes and holds out_valid low until enough history exists for the active delay.
module delay_line_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int unsigned A_WIDTH = A_WIDTH_DEF,
    parameter int unsigned MIN_OFF = MIN_OFFSET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sample_tick,
    input  logic [A_WIDTH-1:0] offset_in,
    input  logic               offset_load,
    output logic               ptr_en,
    output logic               wr,
    output logic               rd,
    output logic [A_WIDTH-1:0] offset,
    output logic               out_valid,
    output logic               filling
);

    localparam logic [A_WIDTH-1:0] FILL_MAX  = '1;
    localparam logic [A_WIDTH-1:0] OFF_FLOOR = A_WIDTH'(MIN_OFF);

    dl_state_t          state;
    dl_state_t          state_nxt;
    logic [A_WIDTH-1:0] fill_cnt;
    logic [A_WIDTH-1:0] fill_cnt_nxt;
    logic [A_WIDTH-1:0] fill_inc;
    logic [A_WIDTH-1:0] offset_nxt;
    logic [A_WIDTH-1:0] ld_clamped;
    logic [A_WIDTH-1:0] ld_val;
    logic [A_WIDTH-1:0] ld_val_nxt;
    logic               ld_pend;
    logic               ld_pend_nxt;
    logic               ld_now;
    logic               ld_apply;
    logic               busy;
    logic               tick_acc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, fill counter and offset capture
    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        offset_nxt   = offset;
        ld_pend_nxt  = 1'b0;
        ld_val_nxt   = ld_val;

        busy       = wr | ptr_en;
        tick_acc   = sample_tick & en & (state != IDLE) & ~busy;
        ld_clamped = (offset_in < OFF_FLOOR) ? OFF_FLOOR : offset_in;
        fill_inc   = (fill_cnt == FILL_MAX) ? fill_cnt : A_WIDTH'(fill_cnt + 1'b1);

        // A load landing on an accepted tick waits one cycle so that tick reads with the old offset
        ld_now   = offset_load & ~tick_acc;
        ld_apply = ld_now | ld_pend;
        if (offset_load && tick_acc) begin
            ld_pend_nxt = 1'b1;
            ld_val_nxt  = ld_clamped;
        end
        if (ld_apply) begin
            offset_nxt = ld_now ? ld_clamped : ld_val;
        end

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt    = FILL;
                    fill_cnt_nxt = '0;
                end
            end
            FILL, RUN: begin
                if (!en && !wr) begin
                    state_nxt    = IDLE;
                    fill_cnt_nxt = '0;
                end else if (ld_apply) begin
                    state_nxt    = FILL;
                    fill_cnt_nxt = '0;
                end else if (state == FILL && wr) begin
                    fill_cnt_nxt = fill_inc;
                    if (fill_inc == offset) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt    = IDLE;
                fill_cnt_nxt = '0;
            end
        endcase
    end

    // Pulse pipeline and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr        <= 1'b0;
            rd        <= 1'b0;
            ptr_en    <= 1'b0;
            out_valid <= 1'b0;
            filling   <= 1'b0;
            offset    <= OFF_FLOOR;
            fill_cnt  <= '0;
            ld_pend   <= 1'b0;
            ld_val    <= OFF_FLOOR;
        end else begin
            wr        <= tick_acc;
            rd        <= tick_acc;
            ptr_en    <= wr;
            out_valid <= rd & (state == RUN);
            filling   <= (state_nxt == FILL);
            offset    <= offset_nxt;
            fill_cnt  <= fill_cnt_nxt;
            ld_pend   <= ld_pend_nxt;
            ld_val    <= ld_val_nxt;
        end
    end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Randomised scoreboard bench for delay_line_ctrl with a behavioural RAM datapath.
module tb_delay_line_ctrl;

    localparam int unsigned AW = 9;
    localparam int M_IDLE = 0;
    localparam int M_FILL = 1;
    localparam int M_RUN  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sample_tick;
    logic [AW-1:0] offset_in;
    logic          offset_load;
    logic          ptr_en;
    logic          wr;
    logic          rd;
    logic [AW-1:0] offset;
    logic          out_valid;
    logic          filling;

    always #5 clk = ~clk;

    delay_line_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sample_tick(sample_tick),
        .offset_in  (offset_in),
        .offset_load(offset_load),
        .ptr_en     (ptr_en),
        .wr         (wr),
        .rd         (rd),
        .offset     (offset),
        .out_valid  (out_valid),
        .filling    (filling)
    );

    // Behavioural datapath: pointer counter plus dual-port RAM with one-cycle read
    logic [15:0]   din;
    logic [15:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] wp = '0;
    logic [AW-1:0] rd_addr;
    logic [15:0]   dout;

    assign rd_addr = wp - offset;

    always @(posedge clk) begin
        if (wr === 1'b1) mem[wp] <= din;
        if (rd === 1'b1) dout <= mem[rd_addr];
        if (ptr_en === 1'b1) wp <= AW'(wp + 1'b1);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } ov_t;

    int  wr_q[$];
    int  ptr_q[$];
    ov_t ov_q[$];

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int ov_cnt   = 0;

    // Reference model state (tick-level view of the sequencer)
    int          mode;
    int          moff;
    int          fill;
    int          last_acc;
    logic [15:0] hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // One clock cycle of stimulus; the model predicts the resulting pulses
    task automatic step(input logic tk, input logic ld, input logic [AW-1:0] v, input logic r);
        int   n;
        logic acc;
        sample_tick = tk;
        offset_load = ld;
        offset_in   = v;
        rst         = r;
        if (r) begin
            while (wr_q.size() > 0 && wr_q[$] > cyc) void'(wr_q.pop_back());
            while (ptr_q.size() > 0 && ptr_q[$] > cyc) void'(ptr_q.pop_back());
            while (ov_q.size() > 0 && ov_q[$].cyc > cyc) void'(ov_q.pop_back());
            mode     = M_IDLE;
            moff     = 1;
            fill     = 0;
            last_acc = -100;
            hist.delete();
        end else begin
            acc = tk && en && (mode != M_IDLE) && (cyc - last_acc >= 3);
            if (acc) begin
                din      = 16'($urandom);
                last_acc = cyc;
                hist.push_back(din);
                n = hist.size() - 1;
                wr_q.push_back(cyc + 1);
                ptr_q.push_back(cyc + 2);
                if (mode == M_RUN && n >= moff) ov_q.push_back('{cyc + 2, hist[n - moff]});
                if (mode == M_FILL) begin
                    fill++;
                    if (fill >= moff) mode = M_RUN;
                end
            end
            if (ld) begin
                moff = (v == 0) ? 1 : int'(v);
                fill = 0;
                if (mode != M_IDLE) mode = M_FILL;
            end
            if (en && mode == M_IDLE) mode = M_FILL;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic ticks(input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            idle(gap - 1);
        end
    endtask

    task automatic settle_check(input string tag);
        chk({tag, ".filling"}, 32'(filling), 32'(mode == M_FILL));
        chk({tag, ".offset"}, 32'(offset), 32'(moff));
    endtask

    task automatic reset_check(input string tag);
        chk({tag, ".wr"}, 32'(wr), 0);
        chk({tag, ".rd"}, 32'(rd), 0);
        chk({tag, ".ptr_en"}, 32'(ptr_en), 0);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".filling"}, 32'(filling), 0);
        chk({tag, ".offset"}, 32'(offset), 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT should or does pulse
    always @(negedge clk) begin : mon
        logic        e_wr;
        logic        e_ptr;
        logic        e_ov;
        logic [15:0] e_d;
        if (cyc > 0) begin
            e_wr = (wr_q.size() > 0) && (wr_q[0] == cyc);
            if (e_wr) void'(wr_q.pop_front());
            if (e_wr || wr !== 1'b0 || rd !== 1'b0) begin
                chk("wr", 32'(wr), 32'(e_wr));
                chk("rd", 32'(rd), 32'(e_wr));
            end
            if (wr === 1'b1) wr_cnt++;

            e_ptr = (ptr_q.size() > 0) && (ptr_q[0] == cyc);
            if (e_ptr) void'(ptr_q.pop_front());
            if (e_ptr || ptr_en !== 1'b0) chk("ptr_en", 32'(ptr_en), 32'(e_ptr));

            e_ov = (ov_q.size() > 0) && (ov_q[0].cyc == cyc);
            e_d  = '0;
            if (e_ov) begin
                e_d = ov_q[0].data;
                void'(ov_q.pop_front());
            end
            if (e_ov || out_valid !== 1'b0) chk("out_valid", 32'(out_valid), 32'(e_ov));
            if (e_ov && out_valid === 1'b1) chk("delayed_sample", 32'(dout), 32'(e_d));
            if (out_valid === 1'b1) ov_cnt++;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : drive
        int   b;
        logic tk;
        logic ld;
        logic rs;
        logic [AW-1:0] v;
        rst = 1'b1; en = 1'b0; sample_tick = 1'b0; offset_load = 1'b0; offset_in = '0; din = '0;
        mode = M_IDLE; moff = 1; fill = 0; last_acc = -100;

        repeat (3) step(1'b0, 1'b0, '0, 1'b1);
        reset_check("reset");

        // offset 4, ticks every 4 cycles: first out_valid on tick 5
        en = 1'b1;
        step(1'b0, 1'b1, AW'(4), 1'b0);
        idle(3);
        settle_check("fill4");
        b = ov_cnt;
        ticks(3, 4);
        settle_check("after_tick3");
        ticks(1, 4);
        settle_check("after_tick4");
        ticks(4, 4);
        chk("ov_count_offset4", 32'(ov_cnt - b), 4);

        // offset 0 clamps to 1; output resumes on the 2nd tick
        step(1'b0, 1'b1, AW'(0), 1'b0);
        idle(2);
        settle_check("load0");
        b = ov_cnt;
        ticks(3, 4);
        chk("ov_count_offset1", 32'(ov_cnt - b), 2);

        // load coincident with a tick: that read keeps offset 4
        step(1'b0, 1'b1, AW'(4), 1'b0);
        idle(2);
        ticks(5, 4);
        step(1'b1, 1'b1, AW'(8), 1'b0);
        idle(3);
        settle_check("coincident");
        b = ov_cnt;
        ticks(9, 4);
        chk("ov_count_offset8", 32'(ov_cnt - b), 1);

        // ticks 2 cycles apart: every second one is dropped
        b = wr_cnt;
        ticks(10, 2);
        idle(3);
        chk("wr_count_gap2", 32'(wr_cnt - b), 5);

        // reset the cycle after a tick drops the rest of the sequence
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        reset_check("mid_reset");
        idle(4);

        // maximum offset across pointer wrap
        step(1'b0, 1'b1, AW'(511), 1'b0);
        idle(2);
        b = ov_cnt;
        ticks(600, 3);
        idle(3);
        chk("ov_count_offset511", 32'(ov_cnt - b), 89);
        settle_check("wrap");

        // random ticks, loads and rare resets
        repeat (500) begin
            tk = ($urandom_range(0, 99) < 45);
            ld = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 9) == 0) ? AW'(0) : AW'($urandom_range(1, 12));
            rs = ($urandom_range(0, 199) == 0);
            step(tk, ld, v, rs);
        end
        idle(4);
        settle_check("random_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
